dcache_pmem_axi: RTL
====================

Name: dcache_pmem_axi

Overview:
- Converts the data-cache pmem request/response interface into an AXI4 master, 32-bit data, INCR bursts only.
- Its pmem slave port connects directly to the outport of the cached/uncached pmem mux; its AXI master port goes to the memory interconnect.
- Holds one transaction in flight at a time.
- Reads return one pmem ack per beat. Writes return a single ack when the B response arrives.

Parameters:
- AXI_ID, 4'd0: constant ID driven on awid_o and arid_o.

Ports:
- clk_i in 1: clock.
- rst_i in 1: reset, asynchronous, active-high.
- inport_wr_i in 4: write byte strobes; nonzero means a write beat.
- inport_rd_i in 1: read request.
- inport_len_i in 8: burst length minus one (0..255). Sampled on the first beat only.
- inport_addr_i in 32: byte address. Sampled on the first beat only.
- inport_write_data_i in 32: write data for the current beat.
- inport_accept_o out 1: request or beat accepted this cycle.
- inport_ack_o out 1: response pulse (once per read beat, once per write burst).
- inport_error_o out 1: error qualifier; valid when ack is high.
- inport_read_data_o out 32: read beat data; valid when ack is high.
- axi_awvalid_o out 1, axi_awaddr_o out 32, axi_awid_o out 4, axi_awlen_o out 8, axi_awburst_o out 2: AW channel.
- axi_awready_i in 1: AW ready.
- axi_wvalid_o out 1, axi_wdata_o out 32, axi_wstrb_o out 4, axi_wlast_o out 1: W channel.
- axi_wready_i in 1: W ready.
- axi_bvalid_i in 1, axi_bresp_i in 2, axi_bid_i in 4: B channel.
- axi_bready_o out 1: B ready.
- axi_arvalid_o out 1, axi_araddr_o out 32, axi_arid_o out 4, axi_arlen_o out 8, axi_arburst_o out 2: AR channel.
- axi_arready_i in 1: AR ready.
- axi_rvalid_i in 1, axi_rdata_i in 32, axi_rresp_i in 2, axi_rid_i in 4, axi_rlast_i in 1: R channel.
- axi_rready_o out 1: R ready.

Behaviour:
- Reset: FSM to IDLE. All AXI valids, ack, error, read_data, beat counter and latched address/len/data registers clear to 0.
- Constants: axi_bready_o and axi_rready_o are tied to 1; pmem has no response backpressure. Burst outputs are fixed at 2'b01 (INCR). AXI addresses are driven with [1:0] forced to 0. Incoming IDs are ignored.
- FSM states: IDLE, RD, WR_DATA, WR_RESP.
- IDLE:
  - inport_accept_o=1.
  - If rd_i: latch addr and len, set arvalid, go to RD. Read wins if rd_i and wr_i!=0 arrive together; the wr strobes are ignored.
  - Else if wr_i!=0: latch addr and len, set awvalid, load the W register (data, strb, wlast=(len==0)), set wvalid, set beat count=1. Go to WR_DATA, or to WR_RESP if len==0.
- RD:
  - accept=0. arvalid is held with stable payload until arready, then cleared.
  - Each R handshake registers ack=1, read_data=rdata and error=rresp[1] on the next cycle (one-cycle response latency).
  - rlast returns the FSM to IDLE, independent of the beat count.
- WR_DATA:
  - accept = !wvalid_q || axi_wready_i; the W register is a single-entry skid.
  - An accepted beat loads the W register and increments the count. wlast = (count == len_q).
  - After accepting the beat with count==len_q, go to WR_RESP.
  - awvalid drops on awready and is independent of W ordering; W may complete before AW.
- WR_RESP:
  - accept=0.
  - Wait until both AW and the final W have handshaked, then for bvalid.
  - On bvalid: next cycle ack=1, error=bresp[1], read_data unchanged. Go to IDLE.
- Pulses: ack and error are single-cycle. R or B handshakes outside RD/WR_RESP are dropped with no ack.
- Widths and wrap: beat counter is 9 bits, so len=255 gives 256 beats. Addresses are not incremented locally; the AXI slave handles INCR.
- Back-to-back: IDLE may accept a new request in the same cycle the previous ack is driven.

Test Plan:
- Single read: rd addr 0x1000_0003 len 0, arready=1, rvalid+rlast next cycle with rdata 0xDEADBEEF → araddr 0x1000_0000, arlen 0; one ack with data 0xDEADBEEF, error 0, one cycle after the R handshake.
- 8-beat read with rresp=SLVERR on beat 3 → 8 acks; error=1 only on the 3rd ack; FSM back in IDLE after rlast.
- 8-beat write with wready toggling 1/0 and awready delayed 5 cycles → accept only when the skid has room; exactly 8 W beats, wlast on the 8th; one ack after bvalid, error 0.
- Single write, wstrb 4'b0011, bresp=DECERR → awlen 0, wlast=1 on the first beat, ack with error=1.
- Simultaneous rd=1 and wr=4'hF in IDLE → only AR issued; awvalid and wvalid stay 0.
- rst_i asserted mid-burst (beat 4 of 8 write) → all valids and ack deasserted immediately; after release, accept=1 in IDLE and a new read completes normally.

Source files
------------

// File: rtl/dcache_pmem_axi.sv
// Data-cache pmem request/response port to AXI4 master bridge.
// One transaction in flight, 32-bit data, INCR bursts only.
module dcache_pmem_axi #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  inport_wr_i,
  input  logic        inport_rd_i,
  input  logic [7:0]  inport_len_i,
  input  logic [31:0] inport_addr_i,
  input  logic [31:0] inport_write_data_i,
  output logic        inport_accept_o,
  output logic        inport_ack_o,
  output logic        inport_error_o,
  output logic [31:0] inport_read_data_o,
  output logic        axi_awvalid_o,
  output logic [31:0] axi_awaddr_o,
  output logic [3:0]  axi_awid_o,
  output logic [7:0]  axi_awlen_o,
  output logic [1:0]  axi_awburst_o,
  input  logic        axi_awready_i,
  output logic        axi_wvalid_o,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  output logic        axi_wlast_o,
  input  logic        axi_wready_i,
  input  logic        axi_bvalid_i,
  input  logic [1:0]  axi_bresp_i,
  input  logic [3:0]  axi_bid_i,
  output logic        axi_bready_o,
  output logic        axi_arvalid_o,
  output logic [31:0] axi_araddr_o,
  output logic [3:0]  axi_arid_o,
  output logic [7:0]  axi_arlen_o,
  output logic [1:0]  axi_arburst_o,
  input  logic        axi_arready_i,
  input  logic        axi_rvalid_i,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  input  logic [3:0]  axi_rid_i,
  input  logic        axi_rlast_i,
  output logic        axi_rready_o
);

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned LenW  = 8;
  localparam int unsigned CntW  = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_DATA,
    ST_WR_RESP
  } state_t;

  state_t             state_q, state_d;
  logic               arvalid_q, arvalid_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               wlast_q, wlast_d;
  logic               ack_q, ack_d;
  logic               error_q, error_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [DataW-1:0]   wdata_q, wdata_d;
  logic [DataW-1:0]   rdata_q, rdata_d;
  logic [LenW-1:0]    len_q, len_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               accept_c;
  logic               last_beat_c;
  logic               unused_c;

  // IDs, low address bits and the low response bit carry no information here
  assign unused_c = ^{axi_bid_i, axi_rid_i, axi_rresp_i[0], axi_bresp_i[0], inport_addr_i[1:0]};

  assign last_beat_c = (count_q == CntW'(len_q));

  // Next-state, handshake bookkeeping and response generation
  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    count_d   = count_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    error_d   = 1'b0;
    accept_c  = 1'b0;

    if (arvalid_q && axi_arready_i) arvalid_d = 1'b0;
    if (awvalid_q && axi_awready_i) awvalid_d = 1'b0;
    if (wvalid_q && axi_wready_i)   wvalid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        accept_c = 1'b1;
        if (inport_rd_i) begin
          addr_d    = {inport_addr_i[31:2], 2'b00};
          len_d     = inport_len_i;
          arvalid_d = 1'b1;
          state_d   = ST_RD;
        end else if (|inport_wr_i) begin
          addr_d    = {inport_addr_i[31:2], 2'b00};
          len_d     = inport_len_i;
          awvalid_d = 1'b1;
          wdata_d   = inport_write_data_i;
          wstrb_d   = inport_wr_i;
          wlast_d   = (inport_len_i == '0);
          wvalid_d  = 1'b1;
          count_d   = CntW'(1);
          state_d   = (inport_len_i == '0) ? ST_WR_RESP : ST_WR_DATA;
        end
      end
      ST_RD: begin
        if (axi_rvalid_i) begin
          ack_d   = 1'b1;
          rdata_d = axi_rdata_i;
          error_d = axi_rresp_i[1];
          if (axi_rlast_i) state_d = ST_IDLE;
        end
      end
      ST_WR_DATA: begin
        // W register is a single-entry skid: refill when empty or draining
        accept_c = !wvalid_q || axi_wready_i;
        if (accept_c && (|inport_wr_i)) begin
          wdata_d  = inport_write_data_i;
          wstrb_d  = inport_wr_i;
          wlast_d  = last_beat_c;
          wvalid_d = 1'b1;
          count_d  = count_q + CntW'(1);
          if (last_beat_c) state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (!awvalid_q && !wvalid_q && axi_bvalid_i) begin
          ack_d   = 1'b1;
          error_d = axi_bresp_i[1];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and payload registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      count_q   <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      error_q   <= error_d;
    end
  end

  assign inport_accept_o    = accept_c;
  assign inport_ack_o       = ack_q;
  assign inport_error_o     = error_q;
  assign inport_read_data_o = rdata_q;

  assign axi_awvalid_o = awvalid_q;
  assign axi_awaddr_o  = addr_q;
  assign axi_awid_o    = AXI_ID;
  assign axi_awlen_o   = len_q;
  assign axi_awburst_o = 2'b01;
  assign axi_wvalid_o  = wvalid_q;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = wstrb_q;
  assign axi_wlast_o   = wlast_q;
  assign axi_bready_o  = 1'b1;
  assign axi_arvalid_o = arvalid_q;
  assign axi_araddr_o  = addr_q;
  assign axi_arid_o    = AXI_ID;
  assign axi_arlen_o   = len_q;
  assign axi_arburst_o = 2'b01;
  assign axi_rready_o  = 1'b1;

endmodule
